router_pkt_src: RTL and testbench

ROUTER_PKT_SRC -- requirements
Module: router_pkt_src

---
 rtl/router_pkt_src_if.sv | 27 ++
 rtl/router_pkt_src.sv | 145 ++++++++++++++
 tb/tb_router_pkt_src.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_pkt_src_if.sv
// Host-command, payload-write and router-side signals of router_pkt_src.
// master = host/router side, slave = router_pkt_src itself.
interface router_pkt_src_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_addr;
    logic [5:0] cmd_len;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       busy;
    logic       pkt_valid;
    logic [7:0] pkt_data;
    logic       pkt_done;
    logic       cmd_err;
    logic       inject_err;

    modport master (
        output cmd_valid, cmd_addr, cmd_len, wr_valid, wr_data, busy, inject_err,
        input  cmd_ready, wr_ready, pkt_valid, pkt_data, pkt_done, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, wr_valid, wr_data, busy, inject_err,
        output cmd_ready, wr_ready, pkt_valid, pkt_data, pkt_done, cmd_err
    );
endinterface

// File: rtl/router_pkt_src.sv
// Packet source for the router: buffers a command's payload, then streams header, payload and parity.
// Optional macro ROUTER_PKT_SRC_ERR_INJ_EN: inject_err at command accept inverts the parity byte.
module router_pkt_src (
    input  logic            clock,
    input  logic            reset,
    router_pkt_src_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, HDR, PAY, PAR, DONE} state_t;

    state_t     state, state_nxt;
    logic [7:0] header_q;
    logic [7:0] parity_q;
    logic [5:0] wr_idx;
    logic [5:0] rd_idx;
    logic [7:0] pay_buf [0:62];
    logic       run_q;
    logic       err_q;
    logic       cmd_fire;
    logic       cmd_legal;
    logic       wr_fire;
    logic       xfer;
    logic [5:0] last_idx;
    logic [7:0] par_out;

    // Handshakes are qualified from state, not from the ready outputs, to keep the comb path acyclic.
    assign cmd_fire  = (state == IDLE) && run_q && bus.cmd_valid;
    assign cmd_legal = (bus.cmd_len != 6'd0) && (bus.cmd_addr != 2'd3);
    assign wr_fire   = (state == LOAD) && bus.wr_valid;
    assign xfer      = !bus.busy;
    assign last_idx  = header_q[7:2] - 6'd1;
    assign bus.cmd_err = err_q;

`ifdef ROUTER_PKT_SRC_ERR_INJ_EN
    logic inj_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inj_q <= 1'b0;
        end else if (cmd_fire && cmd_legal) begin
            inj_q <= bus.inject_err;
        end
    end

    assign par_out = inj_q ? ~parity_q : parity_q;
`else
    logic unused_inject_err;

    assign unused_inject_err = bus.inject_err;
    assign par_out = parity_q;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.cmd_ready = 1'b0;
        bus.wr_ready  = 1'b0;
        bus.pkt_valid = 1'b0;
        bus.pkt_data  = '0;
        bus.pkt_done  = 1'b0;
        case (state)
            IDLE: begin
                bus.cmd_ready = run_q;
                if (cmd_fire && cmd_legal) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                bus.wr_ready = 1'b1;
                if (wr_fire && (wr_idx == last_idx)) begin
                    state_nxt = HDR;
                end
            end
            HDR: begin
                bus.pkt_valid = 1'b1;
                bus.pkt_data  = header_q;
                if (xfer) begin
                    state_nxt = PAY;
                end
            end
            PAY: begin
                bus.pkt_valid = 1'b1;
                bus.pkt_data  = pay_buf[rd_idx];
                if (xfer && (rd_idx == last_idx)) begin
                    state_nxt = PAR;
                end
            end
            PAR: begin
                bus.pkt_data = par_out;
                if (xfer) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.pkt_done = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // run_q keeps cmd_ready low until the first edge after reset release.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            header_q <= '0;
            parity_q <= '0;
            wr_idx   <= '0;
            rd_idx   <= '0;
            run_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            run_q <= 1'b1;
            err_q <= 1'b0;
            if (cmd_fire) begin
                if (cmd_legal) begin
                    header_q <= {bus.cmd_len, bus.cmd_addr};
                    parity_q <= {bus.cmd_len, bus.cmd_addr};
                    wr_idx   <= '0;
                    rd_idx   <= '0;
                end else begin
                    err_q <= 1'b1;
                end
            end
            if (wr_fire) begin
                parity_q <= parity_q ^ bus.wr_data;
                wr_idx   <= wr_idx + 6'd1;
            end
            if ((state == PAY) && xfer) begin
                rd_idx <= rd_idx + 6'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (wr_fire) begin
            pay_buf[wr_idx] <= bus.wr_data;
        end
    end
endmodule

// File: tb/tb_router_pkt_src.sv
// Randomized scoreboard bench for router_pkt_src: stimulus queues the expected packet stream,
// a negedge monitor pops and compares whatever the router side presents.
`timescale 1ns/1ps
module tb_router_pkt_src;
    logic clock = 1'b0;
    logic reset;

    router_pkt_src_if bus();

    router_pkt_src dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // kind: 0 = valid byte (header or payload), 1 = parity byte, 2 = done pulse
    typedef struct {
        int unsigned kind;
        logic [7:0]  data;
        int unsigned len;
    } item_t;

    item_t exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    logic        prev_valid = 1'b0;
    logic        in_par     = 1'b0;
    logic [7:0]  par_hold   = '0;
    int unsigned nb_cnt     = 0;
    item_t       it;

    always @(negedge clock) begin
        if (reset) begin
            check("reset_outputs",
                  {bus.pkt_valid, bus.pkt_data, bus.cmd_ready, bus.wr_ready, bus.pkt_done, bus.cmd_err}, '0);
            prev_valid = 1'b0;
            in_par     = 1'b0;
            nb_cnt     = 0;
        end else begin
            if (bus.pkt_done) begin
                check("done_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    it = exp_q.pop_front();
                    check("done_kind", it.kind, 2);
                    check("packet_cycles", nb_cnt, it.len + 2);
                end
                check("done_data", bus.pkt_data, 8'h00);
                in_par = 1'b0;
                nb_cnt = 0;
            end else if (bus.pkt_valid) begin
                check("valid_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    if (!bus.busy) begin
                        it = exp_q.pop_front();
                        check("byte_kind", it.kind, 0);
                        check("byte_data", bus.pkt_data, it.data);
                        nb_cnt++;
                    end else begin
                        check("stall_hold_data", bus.pkt_data, exp_q[0].data);
                    end
                end
            end else if (prev_valid) begin
                check("parity_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    it = exp_q.pop_front();
                    check("parity_kind", it.kind, 1);
                    check("parity_data", bus.pkt_data, it.data);
                    par_hold = it.data;
                end
                in_par = 1'b1;
                if (!bus.busy) nb_cnt++;
            end else if (in_par) begin
                check("parity_hold", bus.pkt_data, par_hold);
                if (!bus.busy) nb_cnt++;
            end else begin
                check("idle_data_zero", bus.pkt_data, 8'h00);
            end
            prev_valid = bus.pkt_valid;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input int unsigned cycles);
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("reset_async_valid", bus.pkt_valid, 0);
        check("reset_async_data", bus.pkt_data, 8'h00);
        repeat (cycles) tick();
        reset = 1'b0;
        @(negedge clock);
        check("ready_low_after_release", bus.cmd_ready, 0);
        tick();
        @(negedge clock);
        check("ready_rises", bus.cmd_ready, 1);
        tick();
    endtask

    task automatic send(input logic [1:0] addr, input logic [5:0] len, input logic inj,
                        input int unsigned mode);
        logic [7:0]  bytes[$];
        logic [7:0]  hdr;
        logic [7:0]  par;
        logic [7:0]  b;
        logic        r;
        logic        ok;
        logic        done;
        logic        legal;
        int unsigned n;

        legal = (len != 6'd0) && (addr != 2'd3);
        bus.cmd_valid  = 1'b1;
        bus.cmd_addr   = addr;
        bus.cmd_len    = len;
        bus.inject_err = inj;
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clock);
            r = bus.cmd_ready;
            tick();
            ok = r;
        end
        bus.cmd_valid  = 1'b0;
        bus.cmd_addr   = 2'($urandom);
        bus.cmd_len    = 6'($urandom);
        bus.inject_err = 1'($urandom);
        check("cmd_accepted", ok, 1);
        if (!ok) return;

        if (!legal) begin
            @(negedge clock);
            check("cmd_err_pulse", bus.cmd_err, 1);
            check("cmd_err_ready", bus.cmd_ready, 1);
            check("cmd_err_no_pkt", bus.pkt_valid, 0);
            tick();
            @(negedge clock);
            check("cmd_err_single", bus.cmd_err, 0);
            check("cmd_err_still_idle", bus.cmd_ready, 1);
            tick();
            return;
        end

        // Reference packet: header, payload, XOR of all of them (inverted on injection when enabled).
        hdr = {len, addr};
        par = hdr;
        for (int i = 0; i < int'(len); i++) begin
            b = 8'($urandom);
            bytes.push_back(b);
            par = par ^ b;
        end
`ifdef ROUTER_PKT_SRC_ERR_INJ_EN
        if (inj) par = ~par;
`endif
        exp_q.push_back('{kind: 0, data: hdr, len: 0});
        foreach (bytes[i]) exp_q.push_back('{kind: 0, data: bytes[i], len: 0});
        exp_q.push_back('{kind: 1, data: par, len: 0});
        exp_q.push_back('{kind: 2, data: 8'h00, len: len});

        @(negedge clock);
        check("legal_no_err", bus.cmd_err, 0);
        check("load_ready_low", bus.cmd_ready, 0);
        tick();

        n = 0;
        for (int t = 0; t < 400 && n < len; t++) begin
            bus.wr_valid   = ($urandom_range(0, 3) != 0);
            bus.wr_data    = bus.wr_valid ? bytes[n] : 8'($urandom);
            bus.cmd_valid  = 1'($urandom);
            bus.cmd_addr   = 2'($urandom);
            bus.cmd_len    = 6'($urandom);
            bus.inject_err = 1'($urandom);
            @(negedge clock);
            r = bus.wr_ready;
            tick();
            if (bus.wr_valid && r) n++;
        end
        bus.wr_valid  = 1'b0;
        bus.cmd_valid = 1'b0;
        check("load_complete", n, len);
        if (n != len) return;

        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            case (mode)
                1:       bus.busy = ($urandom_range(0, 2) == 0);
                2:       bus.busy = (c >= 5 && c <= 7);
                default: bus.busy = 1'b0;
            endcase
            bus.wr_valid = 1'($urandom);
            bus.wr_data  = 8'($urandom);
            if (mode == 3 && c == 6) begin
                bus.wr_valid = 1'b0;
                do_reset(2);
                done = 1'b1;
            end else begin
                @(negedge clock);
                if (c == 0) begin
                    check("hdr_next_cycle_valid", bus.pkt_valid, 1);
                    check("hdr_next_cycle_data", bus.pkt_data, hdr);
                end
                done = bus.pkt_done;
                tick();
            end
        end
        bus.busy     = 1'b0;
        bus.wr_valid = 1'b0;
        check("packet_finished", done, 1);
    endtask

    initial begin
        reset          = 1'b1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_addr   = '0;
        bus.cmd_len    = '0;
        bus.wr_valid   = 1'b0;
        bus.wr_data    = '0;
        bus.busy       = 1'b0;
        bus.inject_err = 1'b0;
        do_reset(3);

        send(2'd0, 6'd9, 1'b0, 0);
        send(2'd0, 6'd9, 1'b0, 2);
        send(2'd0, 6'd0, 1'b0, 0);
        send(2'd3, 6'd5, 1'b0, 0);
        send(2'd3, 6'd0, 1'b1, 0);
        send(2'd2, 6'd63, 1'b0, 0);
        send(2'd2, 6'd63, 1'b0, 1);
        send(2'd1, 6'd20, 1'b0, 3);
        send(2'd1, 6'd12, 1'b0, 0);
        send(2'd0, 6'd7, 1'b1, 0);
        send(2'd2, 6'd30, 1'b1, 1);
        send(2'd1, 6'd1, 1'b0, 1);
        for (int k = 0; k < 25; k++) begin
            send(2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), 1'($urandom),
                 $urandom_range(0, 1));
        end

        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
